// File: rtl/sky_sequencer.sv
// Day-cycle fade sequencer: IDLE -> RISE -> HOLD -> FALL -> DARK, advancing one step per frame tick.
// Latency: outputs update on the edge where tick=1 and are visible the next cycle.
// No backpressure: frames without run or a pending step are ignored and all state holds.
module sky_sequencer #(
    parameter int FRAMES_PER_STEP = 2,
    parameter int STEP            = 1,
    parameter int HOLD_FRAMES     = 120,
    parameter int DARK_FRAMES     = 60,
    parameter bit LOOP            = 1'b1
) (
    input  logic       clk_pix,
    input  logic       rst_n,
    input  logic       frame,
    input  logic       run,
    input  logic       step,
    input  logic       restart,
    output logic [7:0] fade_level,
    output logic       direction,
    output logic [2:0] phase,
    output logic       cycle_done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RISE = 3'd1,
        S_HOLD = 3'd2,
        S_FALL = 3'd3,
        S_DARK = 3'd4
    } state_t;

    localparam logic [7:0] FPS_LAST  = 8'(FRAMES_PER_STEP - 1);
    // A zero frame count still costs one frame in that phase.
    localparam logic [9:0] HOLD_LAST = 10'((HOLD_FRAMES == 0) ? 0 : HOLD_FRAMES - 1);
    localparam logic [9:0] DARK_LAST = 10'((DARK_FRAMES == 0) ? 0 : DARK_FRAMES - 1);
    localparam logic [8:0] STEP9     = 9'(STEP);

    state_t     state, state_nxt;
    logic [7:0] fade_nxt;
    logic       dir_nxt;
    logic       cycle_done_nxt;
    logic [7:0] fcnt, fcnt_nxt;
    logic [9:0] hcnt, hcnt_nxt;
    logic       step_pend, step_pend_nxt;
    logic       tick;
    logic [8:0] sum;
    logic [8:0] diff;

    // A step arriving on the same cycle as the frame is consumed by that frame.
    assign tick  = frame & (run | step_pend | step);
    assign sum   = {1'b0, fade_level} + STEP9;
    assign diff  = {1'b0, fade_level} - STEP9;
    assign phase = state;

    always_comb begin
        state_nxt      = state;
        fade_nxt       = fade_level;
        dir_nxt        = direction;
        fcnt_nxt       = fcnt;
        hcnt_nxt       = hcnt;
        cycle_done_nxt = 1'b0;
        step_pend_nxt  = (step_pend | step) & ~tick;

        if (tick) begin
            case (state)
                S_IDLE: begin
                    state_nxt = S_RISE;
                    fcnt_nxt  = '0;
                end
                S_RISE: begin
                    if (fcnt == FPS_LAST) begin
                        fcnt_nxt = '0;
                        if (sum >= 9'd255) begin
                            fade_nxt  = 8'hff;
                            state_nxt = S_HOLD;
                            hcnt_nxt  = '0;
                        end else begin
                            fade_nxt = sum[7:0];
                        end
                    end else begin
                        fcnt_nxt = fcnt + 8'd1;
                    end
                end
                S_HOLD: begin
                    if (hcnt == HOLD_LAST) begin
                        state_nxt = S_FALL;
                        dir_nxt   = 1'b1;
                        fcnt_nxt  = '0;
                    end else begin
                        hcnt_nxt = hcnt + 10'd1;
                    end
                end
                S_FALL: begin
                    if (fcnt == FPS_LAST) begin
                        fcnt_nxt = '0;
                        // diff[8] is the sign of the 9-bit result: set means it went below zero.
                        if (diff[8] || diff == 9'd0) begin
                            fade_nxt  = 8'h00;
                            state_nxt = S_DARK;
                            hcnt_nxt  = '0;
                        end else begin
                            fade_nxt = diff[7:0];
                        end
                    end else begin
                        fcnt_nxt = fcnt + 8'd1;
                    end
                end
                S_DARK: begin
                    if (hcnt == DARK_LAST) begin
                        cycle_done_nxt = 1'b1;
                        dir_nxt        = 1'b0;
                        fcnt_nxt       = '0;
                        state_nxt      = LOOP ? S_RISE : S_IDLE;
                    end else begin
                        hcnt_nxt = hcnt + 10'd1;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end

        if (restart) begin
            state_nxt      = S_IDLE;
            fade_nxt       = 8'h00;
            dir_nxt        = 1'b0;
            fcnt_nxt       = '0;
            hcnt_nxt       = '0;
            cycle_done_nxt = 1'b0;
            step_pend_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            fade_level <= 8'h00;
            direction  <= 1'b0;
            cycle_done <= 1'b0;
            fcnt       <= '0;
            hcnt       <= '0;
            step_pend  <= 1'b0;
        end else begin
            state      <= state_nxt;
            fade_level <= fade_nxt;
            direction  <= dir_nxt;
            cycle_done <= cycle_done_nxt;
            fcnt       <= fcnt_nxt;
            hcnt       <= hcnt_nxt;
            step_pend  <= step_pend_nxt;
        end
    end

endmodule

// File: tb/tb_sky_sequencer.sv
// Bench for sky_sequencer: three instances (base, LOOP=0, STEP=255) checked cycle by cycle
// against a behavioural model through an expected/observed queue pair.
module tb_sky_sequencer;

    typedef struct packed {
        logic [7:0] fade;
        logic       dir;
        logic [2:0] ph;
        logic       cd;
    } out_t;

    typedef struct {
        int st;
        int fade;
        int dir;
        int fcnt;
        int hcnt;
        int pend;
        int cd;
    } mdl_t;

    localparam int GAP = 3;

    int P_FPS  [3] = '{2, 2, 2};
    int P_STEP [3] = '{16, 16, 255};
    int P_HOLD [3] = '{3, 3, 3};
    int P_DARK [3] = '{2, 2, 2};
    int P_LOOP [3] = '{1, 0, 1};

    logic       clk_pix = 1'b0;
    logic       rst_n   = 1'b0;
    logic       frame_i   [3];
    logic       run_i     [3];
    logic       step_i    [3];
    logic       restart_i [3];
    logic [7:0] fade_o    [3];
    logic       dir_o     [3];
    logic [2:0] phase_o   [3];
    logic       cd_o      [3];

    mdl_t m [3];
    out_t exp_q [$];
    out_t obs_q [$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk_pix = ~clk_pix;

    sky_sequencer #(.FRAMES_PER_STEP(2), .STEP(16), .HOLD_FRAMES(3), .DARK_FRAMES(2), .LOOP(1'b1)) u_base (
        .clk_pix(clk_pix), .rst_n(rst_n), .frame(frame_i[0]), .run(run_i[0]), .step(step_i[0]),
        .restart(restart_i[0]), .fade_level(fade_o[0]), .direction(dir_o[0]), .phase(phase_o[0]),
        .cycle_done(cd_o[0]));

    sky_sequencer #(.FRAMES_PER_STEP(2), .STEP(16), .HOLD_FRAMES(3), .DARK_FRAMES(2), .LOOP(1'b0)) u_noloop (
        .clk_pix(clk_pix), .rst_n(rst_n), .frame(frame_i[1]), .run(run_i[1]), .step(step_i[1]),
        .restart(restart_i[1]), .fade_level(fade_o[1]), .direction(dir_o[1]), .phase(phase_o[1]),
        .cycle_done(cd_o[1]));

    sky_sequencer #(.FRAMES_PER_STEP(2), .STEP(255), .HOLD_FRAMES(3), .DARK_FRAMES(2), .LOOP(1'b1)) u_big (
        .clk_pix(clk_pix), .rst_n(rst_n), .frame(frame_i[2]), .run(run_i[2]), .step(step_i[2]),
        .restart(restart_i[2]), .fade_level(fade_o[2]), .direction(dir_o[2]), .phase(phase_o[2]),
        .cycle_done(cd_o[2]));

    function automatic out_t dout(int d);
        out_t o;
        o.fade = fade_o[d];
        o.dir  = dir_o[d];
        o.ph   = phase_o[d];
        o.cd   = cd_o[d];
        return o;
    endfunction

    function automatic out_t mout(int d);
        out_t o;
        o.fade = 8'(m[d].fade);
        o.dir  = 1'(m[d].dir);
        o.ph   = 3'(m[d].st);
        o.cd   = 1'(m[d].cd);
        return o;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) m[k] = '{default: 0};
    endtask

    // Behavioural model of one clock edge, using plain integer arithmetic.
    task automatic model_clk(int d, logic f, logic r, logic s, logic rs);
        mdl_t c, n;
        int   lvl, hold_n, dark_n;
        bit   t;
        c = m[d];
        n = c;
        n.cd = 0;
        hold_n = (P_HOLD[d] < 1) ? 1 : P_HOLD[d];
        dark_n = (P_DARK[d] < 1) ? 1 : P_DARK[d];
        t = f && (r || s || c.pend != 0);
        if (rs) begin
            n = '{default: 0};
        end else begin
            n.pend = t ? 0 : ((s || c.pend != 0) ? 1 : 0);
            if (t) begin
                case (c.st)
                    0: begin n.st = 1; n.fcnt = 0; end
                    1, 3: begin
                        if (c.fcnt < P_FPS[d] - 1) n.fcnt = c.fcnt + 1;
                        else begin
                            n.fcnt = 0;
                            lvl = (c.st == 1) ? c.fade + P_STEP[d] : c.fade - P_STEP[d];
                            if (lvl >= 255) begin n.fade = 255; n.st = 2; n.hcnt = 0; end
                            else if (lvl <= 0) begin n.fade = 0; n.st = 4; n.hcnt = 0; end
                            else n.fade = lvl;
                        end
                    end
                    2: if (c.hcnt + 1 >= hold_n) begin n.st = 3; n.dir = 1; n.fcnt = 0; end
                       else n.hcnt = c.hcnt + 1;
                    4: if (c.hcnt + 1 >= dark_n) begin
                           n.st = (P_LOOP[d] != 0) ? 1 : 0; n.dir = 0; n.cd = 1; n.fcnt = 0;
                       end else n.hcnt = c.hcnt + 1;
                    default: ;
                endcase
            end
        end
        m[d] = n;
    endtask

    task automatic cyc(int d, logic f, logic s, logic rs);
        @(negedge clk_pix);
        frame_i[d] = f;
        step_i[d] = s;
        restart_i[d] = rs;
        for (int k = 0; k < 3; k++) model_clk(k, frame_i[k], run_i[k], step_i[k], restart_i[k]);
        exp_q.push_back(mout(d));
        @(posedge clk_pix);
        #1;
        obs_q.push_back(dout(d));
        frame_i[d] = 1'b0;
        step_i[d] = 1'b0;
        restart_i[d] = 1'b0;
    endtask

    task automatic frames(int d, int n);
        for (int i = 0; i < n; i++) begin
            cyc(d, 1'b1, 1'b0, 1'b0);
            repeat (GAP) cyc(d, 1'b0, 1'b0, 1'b0);
        end
    endtask

    function automatic int cd_count();
        int c = 0;
        foreach (obs_q[i]) if (obs_q[i].cd) c++;
        return c;
    endfunction

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            frame_i[k] = 0; run_i[k] = 0; step_i[k] = 0; restart_i[k] = 0;
        end
        model_reset();
        rst_n = 1'b0;
        #23;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({fade_o[k], dir_o[k], phase_o[k], cd_o[k]} !== 13'd0) begin
                errors++;
                $display("FAIL reset_values dut%0d got %h want 0", k, {fade_o[k], dir_o[k], phase_o[k], cd_o[k]});
            end
        end
        @(negedge clk_pix);
        rst_n = 1'b1;
    endtask

    task automatic test_rise();
        out_t e, o;
        run_i[0] = 1'b1;
        frames(0, 1);
        checks++;
        if (phase_o[0] !== 3'd1) begin errors++; $display("FAIL rise_enter got %0d want 1", phase_o[0]); end
        frames(0, 2);
        checks++;
        if (fade_o[0] !== 8'd16) begin errors++; $display("FAIL rise_f3 got %0d want 16", fade_o[0]); end
        frames(0, 2);
        checks++;
        if (fade_o[0] !== 8'd32) begin errors++; $display("FAIL rise_f5 got %0d want 32", fade_o[0]); end
        frames(0, 26);
        checks++;
        if (fade_o[0] !== 8'd240) begin errors++; $display("FAIL rise_f31 got %0d want 240", fade_o[0]); end
        frames(0, 2);
        checks++;
        if (fade_o[0] !== 8'd255 || phase_o[0] !== 3'd2) begin
            errors++; $display("FAIL rise_sat got %0d/%0d want 255/2", fade_o[0], phase_o[0]);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL rise_seq got %h want %h", o, e); end
        end
    endtask

    task automatic test_hold_fall();
        out_t e, o;
        frames(0, 2);
        checks++;
        if (phase_o[0] !== 3'd2) begin errors++; $display("FAIL hold_stay got %0d want 2", phase_o[0]); end
        frames(0, 1);
        checks++;
        if (phase_o[0] !== 3'd3 || dir_o[0] !== 1'b1) begin
            errors++; $display("FAIL hold_exit got %0d/%0d want 3/1", phase_o[0], dir_o[0]);
        end
        frames(0, 2);
        checks++;
        if (fade_o[0] !== 8'd239) begin errors++; $display("FAIL fall_first got %0d want 239", fade_o[0]); end
        frames(0, 30);
        checks++;
        if (fade_o[0] !== 8'd0 || phase_o[0] !== 3'd4 || dir_o[0] !== 1'b1) begin
            errors++; $display("FAIL fall_floor got %0d/%0d/%0d want 0/4/1", fade_o[0], phase_o[0], dir_o[0]);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL fall_seq got %h want %h", o, e); end
        end
    endtask

    task automatic test_dark_loop();
        out_t e, o;
        frames(0, 2);
        checks++;
        if (cd_count() != 1) begin errors++; $display("FAIL dark_cd_pulse got %0d want 1", cd_count()); end
        checks++;
        if (phase_o[0] !== 3'd1 || dir_o[0] !== 1'b0) begin
            errors++; $display("FAIL dark_loop got %0d/%0d want 1/0", phase_o[0], dir_o[0]);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL dark_seq got %h want %h", o, e); end
        end
        run_i[1] = 1'b1;
        frames(1, 70);
        checks++;
        if (phase_o[1] !== 3'd0 || cd_count() != 1) begin
            errors++; $display("FAIL noloop_idle got %0d/%0d want 0/1", phase_o[1], cd_count());
        end
        run_i[1] = 1'b0;
        frames(1, 4);
        checks++;
        if (phase_o[1] !== 3'd0 || fade_o[1] !== 8'd0) begin
            errors++; $display("FAIL noloop_frozen got %0d/%0d want 0/0", phase_o[1], fade_o[1]);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL noloop_seq got %h want %h", o, e); end
        end
    endtask

    task automatic test_pause_step();
        out_t e, o;
        frames(0, 10);
        checks++;
        if (fade_o[0] !== 8'd80) begin errors++; $display("FAIL pause_start got %0d want 80", fade_o[0]); end
        run_i[0] = 1'b0;
        frames(0, 10);
        checks++;
        if (fade_o[0] !== 8'd80 || phase_o[0] !== 3'd1) begin
            errors++; $display("FAIL pause_frozen got %0d/%0d want 80/1", fade_o[0], phase_o[0]);
        end
        cyc(0, 1'b0, 1'b1, 1'b0);
        frames(0, 3);
        cyc(0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (fade_o[0] !== 8'd96) begin errors++; $display("FAIL step_single got %0d want 96", fade_o[0]); end
        repeat (3) cyc(0, 1'b0, 1'b1, 1'b0);
        frames(0, 3);
        checks++;
        if (fade_o[0] !== 8'd96) begin errors++; $display("FAIL step_multi_hold got %0d want 96", fade_o[0]); end
        cyc(0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (fade_o[0] !== 8'd112) begin errors++; $display("FAIL step_multi got %0d want 112", fade_o[0]); end
        run_i[0] = 1'b1;
        cyc(0, 1'b0, 1'b1, 1'b0);
        frames(0, 1);
        run_i[0] = 1'b0;
        frames(0, 1);
        checks++;
        if (fade_o[0] !== 8'd112) begin errors++; $display("FAIL step_while_run got %0d want 112", fade_o[0]); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL step_seq got %h want %h", o, e); end
        end
    endtask

    task automatic test_restart();
        out_t e, o;
        int   n = 0;
        run_i[0] = 1'b1;
        while (!(phase_o[0] == 3'd3 && fade_o[0] == 8'd143) && n < 200) begin
            frames(0, 1);
            n++;
        end
        checks++;
        if (n >= 200) begin errors++; $display("FAIL restart_reach got %0d/%0d want 3/143", phase_o[0], fade_o[0]); end
        run_i[0] = 1'b0;
        cyc(0, 1'b0, 1'b1, 1'b0);
        cyc(0, 1'b1, 1'b1, 1'b1);
        checks++;
        if ({fade_o[0], dir_o[0], phase_o[0], cd_o[0]} !== 13'd0) begin
            errors++; $display("FAIL restart_clear got %h want 0", {fade_o[0], dir_o[0], phase_o[0], cd_o[0]});
        end
        frames(0, 2);
        checks++;
        if (phase_o[0] !== 3'd0) begin errors++; $display("FAIL restart_pend got %0d want 0", phase_o[0]); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL restart_seq got %h want %h", o, e); end
        end
    endtask

    task automatic test_async_reset();
        out_t e, o;
        int   n = 0;
        run_i[0] = 1'b1;
        while (phase_o[0] != 3'd2 && n < 100) begin
            frames(0, 1);
            n++;
        end
        checks++;
        if (n >= 100 || fade_o[0] !== 8'd255) begin errors++; $display("FAIL arst_reach got %0d want 255", fade_o[0]); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL arst_pre_seq got %h want %h", o, e); end
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({fade_o[0], dir_o[0], phase_o[0], cd_o[0]} !== 13'd0) begin
            errors++; $display("FAIL arst_immediate got %h want 0", {fade_o[0], dir_o[0], phase_o[0], cd_o[0]});
        end
        model_reset();
        @(negedge clk_pix);
        rst_n = 1'b1;
        frames(0, 1);
        checks++;
        if (phase_o[0] !== 3'd1 || fade_o[0] !== 8'd0) begin
            errors++; $display("FAIL arst_resume got %0d/%0d want 1/0", phase_o[0], fade_o[0]);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL arst_seq got %h want %h", o, e); end
        end
    endtask

    task automatic test_step255();
        out_t e, o;
        run_i[0] = 1'b0;
        run_i[2] = 1'b1;
        frames(2, 3);
        checks++;
        if (fade_o[2] !== 8'd255 || phase_o[2] !== 3'd2) begin
            errors++; $display("FAIL big_rise got %0d/%0d want 255/2", fade_o[2], phase_o[2]);
        end
        frames(2, 3);
        checks++;
        if (phase_o[2] !== 3'd3 || dir_o[2] !== 1'b1) begin
            errors++; $display("FAIL big_hold got %0d/%0d want 3/1", phase_o[2], dir_o[2]);
        end
        frames(2, 2);
        checks++;
        if (fade_o[2] !== 8'd0 || phase_o[2] !== 3'd4) begin
            errors++; $display("FAIL big_fall got %0d/%0d want 0/4", fade_o[2], phase_o[2]);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL big_seq got %h want %h", o, e); end
        end
    endtask

    initial begin
        test_reset();
        test_rise();
        test_hold_fall();
        test_dark_loop();
        test_pause_step();
        test_restart();
        test_async_reset();
        test_step255();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

endmodule
